btn_debounce: RTL and testbench



---
 rtl/btn_debounce.sv | 77 +++++++
 tb/tb_btn_debounce.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// Four-channel button conditioner: two-flop synchronizer, per-channel
// stability counter, clean debounced level plus one-cycle press/release pulses.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [3:0] BTN,
  output logic [3:0] DB,
  output logic [3:0] PRESS,
  output logic [3:0] RELEASE
);

  localparam int unsigned     NCH      = 4;
  localparam logic [NCH-1:0]  IDLE_PIN = BTN_ACTIVE_LOW ? '1 : '0;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   p;
  logic [NCH-1:0]   level;
  logic [NCH-1:0]   level_nxt;
  logic [NCH-1:0]   press_nxt;
  logic [NCH-1:0]   release_nxt;
  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];

  // Normalize polarity so that 1 always means pressed.
  assign p  = s2 ^ {NCH{BTN_ACTIVE_LOW}};
  assign DB = level;

  // Per-channel stability counting and transition acceptance.
  always_comb begin
    level_nxt   = level;
    press_nxt   = '0;
    release_nxt = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (p[i] == level[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == LAST) begin
        level_nxt[i]   = p[i];
        cnt_nxt[i]     = '0;
        press_nxt[i]   = p[i];
        release_nxt[i] = ~p[i];
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and registered pulse outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      s1      <= IDLE_PIN;
      s2      <= IDLE_PIN;
      level   <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= BTN;
      s2      <= s1;
      level   <= level_nxt;
      PRESS   <= press_nxt;
      RELEASE <= release_nxt;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with DEBOUNCE_CYCLES = 4, active-low pins.
module tb_btn_debounce;

  logic       clk;
  logic       rstn;
  logic [3:0] btn;
  logic [3:0] db;
  logic [3:0] press;
  logic [3:0] rel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] db;
  } ev_t;

  ev_t exp_q[$];

  btn_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(clk),
    .RSTN(rstn),
    .BTN(btn),
    .DB(db),
    .PRESS(press),
    .RELEASE(rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected pulse dly edges after the current point.
  task automatic expect_ev(input int dly, input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] d);
    ev_t e;
    e.cyc   = cyc + dly;
    e.press = pr;
    e.rel   = rl;
    e.db    = d;
    exp_q.push_back(e);
  endtask

  // Monitor: any pulse must match the oldest expected event.
  always @(negedge clk) begin
    if ((press | rel) != 4'b0000) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse press=%b release=%b db=%b cycle=%0d", press, rel, db, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("press", {28'd0, press}, {28'd0, e.press});
        chk("release", {28'd0, rel}, {28'd0, e.rel});
        chk("db_at_pulse", {28'd0, db}, {28'd0, e.db});
      end
    end
  end

  initial begin
    rstn = 1'b0;
    btn  = 4'hF;

    // Reset held 3 cycles with all buttons released.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_db", {28'd0, db}, 32'd0);
      chk("rst_press", {28'd0, press}, 32'd0);
      chk("rst_release", {28'd0, rel}, 32'd0);
    end
    rstn = 1'b1;
    tick(8);
    chk("post_rst_db", {28'd0, db}, 32'd0);

    // Clean press and release on channel 0.
    btn[0] = 1'b0;
    expect_ev(6, 4'b0001, 4'b0000, 4'b0001);
    tick(10);
    chk("clean_db_held", {28'd0, db}, 32'd1);
    btn[0] = 1'b1;
    expect_ev(6, 4'b0000, 4'b0001, 4'b0000);
    tick(10);

    // Bounce on channel 1: 2-cycle pressed runs never qualify.
    for (int k = 0; k < 5; k++) begin
      btn[1] = 1'b0;
      tick(2);
      btn[1] = 1'b1;
      tick(2);
    end
    chk("bounce_db", {28'd0, db}, 32'd0);
    btn[1] = 1'b0;
    expect_ev(6, 4'b0010, 4'b0000, 4'b0010);
    tick(10);
    btn[1] = 1'b1;
    expect_ev(6, 4'b0000, 4'b0010, 4'b0000);
    tick(10);

    // All channels together.
    btn = 4'h0;
    expect_ev(6, 4'hF, 4'h0, 4'hF);
    tick(10);
    chk("simul_db", {28'd0, db}, 32'hF);
    btn = 4'hF;
    expect_ev(6, 4'h0, 4'hF, 4'h0);
    tick(10);

    // Reset at the 4th edge of a press on channel 2; press re-detected afterwards.
    btn[2] = 1'b0;
    tick(3);
    rstn = 1'b0;
    tick(1);
    chk("midrst_db", {28'd0, db}, 32'd0);
    rstn = 1'b1;
    expect_ev(6, 4'b0100, 4'b0000, 4'b0100);
    tick(10);
    btn[2] = 1'b1;
    expect_ev(6, 4'b0000, 4'b0100, 4'b0000);
    tick(10);

    // 3-cycle glitch on channel 3 must be rejected.
    btn[3] = 1'b0;
    tick(3);
    btn[3] = 1'b1;
    tick(12);
    chk("glitch_db", {28'd0, db}, 32'd0);

    // Bounded drain of outstanding expectations.
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick(1);
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse actual=none required_cycle=%0d press=%b release=%b", e.cyc, e.press, e.rel);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
